// File: rtl/ysyx_24080014_wb_arb_pkg.sv
// Shared constants and types for the GPR write-back arbiter and its load scoreboard.
package ysyx_24080014_wb_arb_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Who won the most recent contended cycle; the other side wins the next one.
  typedef enum logic {
    GRANT_EXU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_24080014_wb_scoreboard.sv
// Busy bit per GPR for loads in flight, with one set port, one clear port and three lookups.
module ysyx_24080014_wb_scoreboard
  import ysyx_24080014_wb_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set_en,
  input  logic [AW-1:0]   i_set_idx,
  input  logic            i_clr_en,
  input  logic [AW-1:0]   i_clr_idx,
  input  logic [AW-1:0]   i_rd_a,
  input  logic [AW-1:0]   i_rd_b,
  input  logic [AW-1:0]   i_rd_c,
  output logic [NREG-1:0] o_busy,
  output logic            o_busy_a,
  output logic            o_busy_b,
  output logic            o_busy_c
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // NOTE: default first, so every path assigns w_busy_nxt and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
    // A new load to the same index outlives the old one returning, so set wins.
    if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy   = r_busy;
  assign o_busy_a = r_busy[i_rd_a];
  assign o_busy_b = r_busy[i_rd_b];
  assign o_busy_c = r_busy[i_rd_c];

endmodule

// File: rtl/ysyx_24080014_wb_arb.sv
// Shares the GPR write port between EXU and LSU, registers one write per cycle,
// and raises a decode stall for sources/destinations with loads in flight.
module ysyx_24080014_wb_arb
  import ysyx_24080014_wb_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exu_valid,
  output logic          exu_ready,
  input  logic [AW-1:0] exu_rd,
  input  logic [DW-1:0] exu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic          issue_load,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          hazard,
  output logic          gpr_wen,
  output logic [AW-1:0] gpr_waddr,
  output logic [DW-1:0] gpr_wdata,
  output logic          idle
);

  grant_e          r_last_grant;
  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;

  logic            w_grant_exu;
  logic            w_grant_lsu;
  logic            w_contend;
  logic [NREG-1:0] w_busy;
  logic            w_busy_rs1;
  logic            w_busy_rs2;
  logic            w_busy_issue;
  logic            w_wb_hit;

  assign w_contend   = exu_valid & lsu_valid;
  assign w_grant_exu = exu_valid & (~lsu_valid | (r_last_grant == GRANT_LSU));
  assign w_grant_lsu = lsu_valid & (~exu_valid | (r_last_grant == GRANT_EXU));
  assign exu_ready   = w_grant_exu;
  assign lsu_ready   = w_grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GRANT_EXU;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      if (w_contend) r_last_grant <= w_grant_lsu ? GRANT_LSU : GRANT_EXU;
      // An rd==0 result is still consumed, it just never reaches the register file.
      if (w_grant_exu) begin
        r_wen   <= (exu_rd != '0);
        r_waddr <= exu_rd;
        r_wdata <= exu_data;
      end else if (w_grant_lsu) begin
        r_wen   <= (lsu_rd != '0);
        r_waddr <= lsu_rd;
        r_wdata <= lsu_data;
      end else begin
        r_wen   <= 1'b0;
      end
    end
  end

  ysyx_24080014_wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (issue_load & (issue_rd != '0)),
    .i_set_idx (issue_rd),
    .i_clr_en  (w_grant_lsu),
    .i_clr_idx (lsu_rd),
    .i_rd_a    (rs1_addr),
    .i_rd_b    (rs2_addr),
    .i_rd_c    (issue_rd),
    .o_busy    (w_busy),
    .o_busy_a  (w_busy_rs1),
    .o_busy_b  (w_busy_rs2),
    .o_busy_c  (w_busy_issue)
  );

  // The register file is not written until the end of this cycle, so a read of
  // the pending index must still wait one cycle after its busy bit drops.
  assign w_wb_hit = r_wen & (r_waddr != '0) &
                    ((r_waddr == rs1_addr) | (r_waddr == rs2_addr));

  assign hazard    = w_busy_rs1 | w_busy_rs2 | (issue_load & w_busy_issue) | w_wb_hit;
  assign gpr_wen   = r_wen;
  assign gpr_waddr = r_waddr;
  assign gpr_wdata = r_wdata;
  assign idle      = (w_busy == '0) & ~r_wen & ~exu_valid & ~lsu_valid;

endmodule
